// File: rtl/mux_74151_pkg.sv
// mux_74151_pkg
// Shared constants and types for the 74x151 8-to-1 data selector model.
//   SEL_W / DATA_W : select width and data width (fixed 3 / 8)
//   Y_INACTIVE     : level of y while the strobe is high or in reset
//   W_INACTIVE     : level of w while the strobe is high or in reset
//   sel_t          : packed {c,b,a} select index
package mux_74151_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    localparam logic Y_INACTIVE = 1'b0;
    localparam logic W_INACTIVE = 1'b1;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_74151_core.sv
// mux_74151_core
// Combinational select/strobe function of the 74x151.
// Ports:
//   n_g  in  1  strobe, active low (1 forces y inactive)
//   d    in  8  data inputs D7..D0
//   sel  in  3  select index {c,b,a}
//   y    out 1  selected data, true polarity
module mux_74151_core
    import mux_74151_pkg::*;
(
    input  logic              n_g,
    input  logic [DATA_W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    sel_t s;
    assign s = sel;

    // Explicit cases rather than d[s] so an unknown strobe or select
    // reaches y as X in a 4-state simulator instead of resolving to a
    // legal-looking value. The defaults are unreachable in hardware.
    always_comb begin
        y = Y_INACTIVE;
        case (n_g)
            1'b1: y = Y_INACTIVE;
            1'b0: begin
                case (s)
                    3'd0:    y = d[0];
                    3'd1:    y = d[1];
                    3'd2:    y = d[2];
                    3'd3:    y = d[3];
                    3'd4:    y = d[4];
                    3'd5:    y = d[5];
                    3'd6:    y = d[6];
                    3'd7:    y = d[7];
                    default: y = 1'bx;
                endcase
            end
            default: y = 1'bx;
        endcase
    end

endmodule

// File: rtl/mux_74151_8to1.sv
// mux_74151_8to1
// 74x151 8-to-1 data selector with active-low strobe and complementary
// outputs. Used in memory decode: {c,b,a} = A14:A12, d = per-bank enables,
// n_g = ~A15, w = active-low upper-RAM chip select.
// Build option: define MUX_74151_OUTREG_EN to register y/w on clk with a
// synchronous active-high reset to the deselected state (y=0, w=1).
// Without it the outputs are combinational and clk/rst are unused.
// Ports:
//   clk  in  1  clock (output register only)
//   rst  in  1  synchronous active-high reset (output register only)
//   n_g  in  1  strobe, active low
//   d    in  8  data inputs D7..D0
//   a    in  1  select bit 0 (LSB)
//   b    in  1  select bit 1
//   c    in  1  select bit 2 (MSB)
//   y    out 1  selected data
//   w    out 1  complement of y
module mux_74151_8to1
    import mux_74151_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              n_g,
    input  logic [DATA_W-1:0] d,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    output logic              y,
    output logic              w
);

    sel_t sel;
    logic y_core;

    assign sel = {c, b, a};

    mux_74151_core u_core (
        .n_g (n_g),
        .d   (d),
        .sel (sel),
        .y   (y_core)
    );

`ifdef MUX_74151_OUTREG_EN
    logic y_d, y_q;
    logic w_d, w_q;

    assign y_d = y_core;
    assign w_d = ~y_core;

    // Both outputs get their own flop so the chip select comes straight
    // off a register; reset values are complementary, so w == ~y always.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= Y_INACTIVE;
            w_q <= W_INACTIVE;
        end else begin
            y_q <= y_d;
            w_q <= w_d;
        end
    end

    assign y = y_q;
    assign w = w_q;
`else
    // clk/rst stay on the port list so both builds share one footprint.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign y = y_core;
    assign w = ~y_core;
`endif

endmodule

// File: tb/tb_mux_74151_8to1.sv
module tb_mux_74151_8to1;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_g;
    logic [7:0] d;
    logic       a, b, c;
    logic       y, w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_74151_8to1 dut (
        .clk (clk),
        .rst (rst),
        .n_g (n_g),
        .d   (d),
        .a   (a),
        .b   (b),
        .c   (c),
        .y   (y),
        .w   (w)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Drive inputs, then wait until they are visible at the outputs.
    task automatic apply(input logic ng, input logic [7:0] dv, input int s);
        logic [2:0] sv;
        sv = 3'(s);
        n_g = ng;
        d   = dv;
        {c, b, a} = sv;
`ifdef MUX_74151_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // w at select index i for d = 8'b0101_0111 (bit i = expected w)
    logic [7:0] bank_w_exp = 8'hA8;

    initial begin
        rst = 1'b1;
        n_g = 1'b0;
        d   = 8'hFF;
        {c, b, a} = 3'd0;

        // reset behaviour
        @(posedge clk); #1;
        @(posedge clk); #1;
`ifdef MUX_74151_OUTREG_EN
        chk("rst_y", y, 1'b0);
        chk("rst_w", w, 1'b1);
        rst = 1'b0;
        chk("rst_rel_hold_y", y, 1'b0);
        @(posedge clk); #1;
        chk("rst_rel_y", y, 1'b1);
        chk("rst_rel_w", w, 1'b0);
        // reset mid-operation wins over live inputs at the next edge
        rst = 1'b1;
        chk("rst_mid_pre_y", y, 1'b1);
        @(posedge clk); #1;
        chk("rst_mid_y", y, 1'b0);
        chk("rst_mid_w", w, 1'b1);
        rst = 1'b0;
`else
        // reset has no effect on the combinational build
        chk("rst_noeff_y", y, 1'b1);
        chk("rst_noeff_w", w, 1'b0);
        rst = 1'b0;
`endif

        // strobe high forces deselect
        for (int s = 0; s < 8; s++) begin
            apply(1'b1, 8'hFF, s);
            chk($sformatf("strobe_y s=%0d", s), y, 1'b0);
            chk($sformatf("strobe_w s=%0d", s), w, 1'b1);
        end

        // upper-RAM decode pattern
        for (int s = 0; s < 8; s++) begin
            apply(1'b0, 8'b0101_0111, s);
            chk($sformatf("bank_w s=%0d", s), w, bank_w_exp[s]);
        end

        // walking one / walking zero
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 8; s++) begin
                apply(1'b0, 8'h01 << i, s);
                chk($sformatf("walk1_y i=%0d s=%0d", i, s), y, (i == s) ? 1'b1 : 1'b0);
                apply(1'b0, ~(8'h01 << i), s);
                chk($sformatf("walk0_w i=%0d s=%0d", i, s), w, (i == s) ? 1'b1 : 1'b0);
            end
        end

        // strobe toggle with s=2, d[2]=1
        apply(1'b0, 8'h04, 2);
        chk("tog0_w", w, 1'b0);
`ifdef MUX_74151_OUTREG_EN
        n_g = 1'b1; #1;
        chk("tog1_hold_w", w, 1'b0);
        @(posedge clk); #1;
        chk("tog1_w", w, 1'b1);
        n_g = 1'b0; #1;
        chk("tog2_hold_w", w, 1'b1);
        @(posedge clk); #1;
        chk("tog2_w", w, 1'b0);
`else
        apply(1'b1, 8'h04, 2);
        chk("tog1_w", w, 1'b1);
        apply(1'b0, 8'h04, 2);
        chk("tog2_w", w, 1'b0);
`endif

        // exhaustive sweep against the reference equation
        for (int v = 0; v < 4096; v++) begin
            logic [11:0] vv;
            logic        ye;
            vv = 12'(v);
            apply(vv[11], vv[7:0], int'(vv[10:8]));
            ye = ~vv[11] & vv[int'(vv[10:8])];
            chk($sformatf("sweep_y v=%03h", vv), y, ye);
            chk($sformatf("sweep_w v=%03h", vv), w, ~ye);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
